// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO. Responds on
//            the CPU data-memory bus beside the data memory.
//            +0 TXDATA (store pushes din[7:0]; loads return 0)
//            +4 STATUS {19'b0, count[12:8], 4'b0, ovf[3], busy[2],
//                       empty[1], full[0]}; store with din[3]=1 clears ovf
// Ports    : clk      - system clock, rising edge
//            rstn     - asynchronous active-low reset
//            addr     - data bus address (window decoded on addr[31:3])
//            din      - store data, only din[7:0] used
//            write_en - store strobe
//            dout     - load data, combinational from addr
//            tx       - serial output, registered, idles high
//            irq      - registered, high while FIFO empty and FSM idle
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        write_en,
    output logic [31:0] dout,
    output logic        tx,
    output logic        irq
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_cnt_w-1:0] c_baud_reload = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one     = c_ptr_w'(1);
    localparam logic [4:0]         c_depth       = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [4:0]         r_count;
    logic               r_ovf;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_irq;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_hit;
    logic w_wr_data;
    logic w_wr_status;
    logic w_unused_bits;

    assign w_hit         = (addr[31:3] == BASE_ADDR[31:3]);
    assign w_wr_data     = write_en && w_hit && !addr[2];
    assign w_wr_status   = write_en && w_hit &&  addr[2];
    assign w_unused_bits = ^{din[31:8], addr[1:0]};

    // ------------------------------------------------------------------
    // FIFO control. Full is judged on the pre-edge count, so a pop in the
    // same cycle does not make room for a store into a full FIFO.
    // ------------------------------------------------------------------
    logic       w_empty;
    logic       w_full;
    logic       w_busy;
    logic       w_baud_zero;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_fifo_head;

    assign w_empty     = (r_count == 5'd0);
    assign w_full      = (r_count == c_depth);
    assign w_busy      = (r_state != S_IDLE);
    assign w_baud_zero = (r_baud_cnt == '0);
    assign w_push      = w_wr_data && !w_full;
    assign w_fifo_head = r_mem[r_rd_ptr];

    // The serialiser takes a byte when idle, or back-to-back at the end of
    // a stop bit so consecutive frames have no idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_zero));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= r_count + {4'd0, w_push} - {4'd0, w_pop};

            if (w_wr_data && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && din[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t w_next_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_baud_zero) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_zero && (r_bit_idx == 3'd7)) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_zero) begin
                    w_next_state = w_empty ? S_IDLE : S_START;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_irq      <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_irq   <= w_empty && (w_next_state == S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= w_fifo_head;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= c_baud_reload;
                    end
                end
                S_START: begin
                    if (w_baud_zero) begin
                        r_tx       <= r_shift[0];
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= c_baud_reload;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - c_cnt_one;
                    end
                end
                S_DATA: begin
                    if (w_baud_zero) begin
                        r_baud_cnt <= c_baud_reload;
                        if (r_bit_idx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - c_cnt_one;
                    end
                end
                S_STOP: begin
                    if (w_baud_zero) begin
                        if (!w_empty) begin
                            r_shift    <= w_fifo_head;
                            r_tx       <= 1'b0;
                            r_baud_cnt <= c_baud_reload;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx  = r_tx;
    assign irq = r_irq;

    always_comb begin
        dout = 32'd0;
        if (w_hit && addr[2]) begin
            dout = {19'd0, r_count, 4'd0, r_ovf, w_busy, w_empty, w_full};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Purpose  : Self-checking bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
//            Stimulus pushes each byte expected on the line into a queue; a
//            monitor decodes frames from tx and compares them to the queue.
//            Register reads and edge timing are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam int c_clk_div = 4;
    localparam int c_frame   = 10 * c_clk_div;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic        write_en = 1'b0;
    logic [31:0] dout;
    logic        tx;
    logic        irq;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0000_FF00),
        .CLK_DIV    (c_clk_div),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .din      (din),
        .write_en (write_en),
        .dout     (dout),
        .tx       (tx),
        .irq      (irq)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         mon_pos  = -1;
    logic [c_frame-1:0] mon_samp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr     = a;
        din      = d;
        write_en = 1'b1;
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr     = a;
        write_en = 1'b0;
        #1;
        chk(name, dout, exp);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && mon_pos < 0 && irq === 1'b1) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 32'(k < 2000), 32'd1);
    endtask

    // Each bit must hold for exactly c_clk_div samples; start low, stop high.
    task automatic frame_done();
        logic       ok;
        logic [7:0] d;
        ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int s = 1; s < c_clk_div; s++) begin
                if (mon_samp[b*c_clk_div+s] !== mon_samp[b*c_clk_div]) ok = 1'b0;
            end
        end
        if (mon_samp[0] !== 1'b0 || mon_samp[9*c_clk_div] !== 1'b1) ok = 1'b0;
        chk("frame_shape", 32'(ok), 32'd1);
        for (int i = 0; i < 8; i++) d[i] = mon_samp[(i+1)*c_clk_div];
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got %h expected no frame at %0t", d, $time);
        end else begin
            chk("frame_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (tx === 1'b0) begin
                mon_samp    = '0;
                mon_samp[0] = 1'b0;
                mon_pos     = 1;
            end
        end else begin
            mon_samp[mon_pos] = tx;
            mon_pos++;
            if (mon_pos == c_frame) begin
                frame_done();
                mon_pos = -1;
            end
        end
    end

    initial begin
        // Reset: idle line, irq set, STATUS shows only the empty flag.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd1);
        addr = 32'h0000_FF04;
        #1;
        chk("rst_status", dout, 32'h0000_0002);
        @(negedge clk);
        rstn = 1'b1;

        // Single byte 0x55: start one edge after the store, irq low for the frame.
        exp_q.push_back(8'h55);
        wr(32'h0000_FF00, 32'h55);
        chk("t2_pre_tx", 32'(tx), 32'd1);
        chk("t2_pre_irq", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_start_tx", 32'(tx), 32'd0);
        chk("t2_busy_irq", 32'(irq), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk("t2_stop_tx", 32'(tx), 32'd1);
        chk("t2_stop_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_done_irq", 32'(irq), 32'd1);
        wait_drain("t2_drain");

        // Back-to-back bytes: no idle gap, 80 cycles to idle.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        wr(32'h0000_FF00, 32'h01);
        wr(32'h0000_FF00, 32'h02);
        chk("t3_start_tx", 32'(tx), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk("t3_stop1_tx", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_no_gap_tx", 32'(tx), 32'd0);
        chk("t3_no_gap_irq", 32'(irq), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk("t3_stop2_irq", 32'(irq), 32'd0);
        chk("t3_stop2_tx", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk("t3_idle_irq", 32'(irq), 32'd1);
        wait_drain("t3_drain");

        // Overfill: A0 goes straight to the shifter, A1..A4 queue, A5 dropped.
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 6; i++) wr(32'h0000_FF00, 32'h0000_00A0 + 32'(i));
        rd("t4_status_full", 32'h0000_FF04, 32'h0000_040D);
        // Stores outside the window change nothing.
        wr(32'h0000_FF0C, 32'h0000_0008);
        wr(32'h0000_0100, 32'h0000_00A9);
        rd("t6_outside_store", 32'h0000_FF04, 32'h0000_040D);
        // STATUS store without bit 3 keeps ovf; with bit 3 clears it.
        wr(32'h0000_FF04, 32'h0000_00F7);
        rd("t4_ovf_keep", 32'h0000_FF04, 32'h0000_040D);
        wr(32'h0000_FF04, 32'h0000_0008);
        rd("t4_ovf_clear", 32'h0000_FF04, 32'h0000_0405);
        rd("t6_load_ff08", 32'h0000_FF08, 32'h0000_0000);
        rd("t6_load_0100", 32'h0000_0100, 32'h0000_0000);
        rd("t6_load_txdata", 32'h0000_FF00, 32'h0000_0000);
        rd("t4_status_alias", 32'h0000_FF06, 32'h0000_0405);
        wait_drain("t4_drain");
        rd("t4_status_idle", 32'h0000_FF04, 32'h0000_0002);

        // Reset in the middle of a data bit (0x3C bit 1 is low).
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        wr(32'h0000_FF00, 32'h3C);
        wr(32'h0000_FF00, 32'h5A);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_pre_reset_tx", 32'(tx), 32'd0);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_async_tx", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd("t5_status", 32'h0000_FF04, 32'h0000_0002);
        chk("t5_irq", 32'(irq), 32'd1);
        repeat (60) @(posedge clk);
        #1;
        chk("t5_idle_tx", 32'(tx), 32'd1);
        wait_drain("t5_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
